// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file widths, types and a one-hot mask helper.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 1 << ADDR_W;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  function automatic reg_mask_t onehot(input logic en, input reg_addr_t a);
    return en ? reg_mask_t'(1) << a : '0;
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write busy vector; a set and clear of one register on the same edge leaves it set.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  output reg_mask_t busy_mask
);
  reg_mask_t busy_q, busy_d;
  always_comb busy_d = (busy_q & ~onehot(clr_en, clr_addr)) | onehot(set_en, set_addr);
  always_ff @(posedge clk) busy_q <= reset ? '0 : busy_d;
  assign busy_mask = busy_q;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: hazard-checked operand read into a one-deep output stage.
// Define OPFETCH_FWD_EN to forward same-cycle write-back data instead of stalling on it.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  reg_addr_t in_src1,
  input  reg_addr_t in_src2,
  input  reg_addr_t in_dst,
  input  logic      in_dst_en,
  output reg_addr_t rf_rd_addr1,
  output reg_addr_t rf_rd_addr2,
  input  word_t     rf_val1,
  input  word_t     rf_val2,
  input  logic      wb_valid,
  input  reg_addr_t wb_addr,
  input  word_t     wb_data,
  output logic      out_valid,
  input  logic      out_ready,
  output word_t     out_op1,
  output word_t     out_op2,
  output reg_addr_t out_dst,
  output logic      out_dst_en,
  output reg_mask_t busy_mask
);
`ifdef OPFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic wb_hit1, wb_hit2, wb_hit_dst, raw1, raw2, waw, accept;
  word_t op1_sel, op2_sel;
  logic valid_q, valid_d, dst_en_q, dst_en_d;
  word_t op1_q, op1_d, op2_q, op2_d;
  reg_addr_t dst_q, dst_d;
  assign rf_rd_addr1 = in_src1;
  assign rf_rd_addr2 = in_src2;
  always_comb begin
    wb_hit1 = wb_valid && wb_addr == in_src1;
    wb_hit2 = wb_valid && wb_addr == in_src2;
    wb_hit_dst = wb_valid && wb_addr == in_dst;
    raw1 = FWD ? busy_mask[in_src1] && !wb_hit1 : busy_mask[in_src1] || wb_hit1;
    raw2 = FWD ? busy_mask[in_src2] && !wb_hit2 : busy_mask[in_src2] || wb_hit2;
    waw = in_dst_en && busy_mask[in_dst] && !wb_hit_dst;
    in_ready = (!valid_q || out_ready) && !(raw1 || raw2 || waw);
    accept = in_valid && in_ready;
    op1_sel = (FWD && wb_hit1) ? wb_data : rf_val1;
    op2_sel = (FWD && wb_hit2) ? wb_data : rf_val2;
    valid_d = accept || (valid_q && !out_ready);
    op1_d = accept ? op1_sel : op1_q;
    op2_d = accept ? op2_sel : op2_q;
    dst_d = accept ? in_dst : dst_q;
    dst_en_d = accept ? in_dst_en : dst_en_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op1_q <= '0;
      op2_q <= '0;
      dst_q <= '0;
      dst_en_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      dst_q <= dst_d;
      dst_en_q <= dst_en_d;
    end
  end
  reg_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (accept && in_dst_en),
    .set_addr (in_dst),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .busy_mask(busy_mask)
  );
  assign out_valid = valid_q;
  assign out_op1 = op1_q;
  assign out_op2 = op2_q;
  assign out_dst = dst_q;
  assign out_dst_en = dst_en_q;
endmodule
